// File: rtl/mul_issue_ctrl.sv
// Operand-issue / result-capture sequencer wrapped around a pipelined multiply cell.
// Holds operands on the cell for MUL_LATENCY cycles and returns the product with its tag.
module mul_issue_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 5,
  parameter int MUL_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic [DATA_W-1:0] mul_src1,
  output logic [DATA_W-1:0] mul_src2,
  input  logic [DATA_W-1:0] mul_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam int CNT_W = 3;

  if (MUL_LATENCY < 1 || MUL_LATENCY > 7) begin : g_bad_latency
    $error("mul_issue_ctrl: MUL_LATENCY must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   tag_q;
  logic               accept;

  // A consumed response frees the slot in the same cycle, so HOLD can accept back-to-back.
  assign req_ready = ~reset & ~flush & ((state == IDLE) | ((state == HOLD) & rsp_ready));
  assign accept    = req_valid & req_ready;

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tag_q      <= '0;
      mul_src1   <= '0;
      mul_src2   <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else if (flush) begin
      // Operand registers keep their values; only the control path is killed.
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      state     <= WAIT;
      cnt       <= CNT_W'(MUL_LATENCY);
      tag_q     <= req_tag;
      mul_src1  <= req_src1;
      mul_src2  <= req_src2;
      rsp_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == '0) begin
            rsp_result <= mul_result;
            rsp_tag    <= tag_q;
            rsp_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: one instance at latency 1, one at latency 3,
// each driving a behavioural pipelined multiply cell.
module tb_mul_issue_ctrl;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
  logic [31:0] req_src1, req_src2, mul_src1, mul_src2, mul_result, rsp_result;
  logic [4:0]  req_tag, rsp_tag;

  logic        r3_req_valid, r3_req_ready, r3_flush, r3_rsp_valid, r3_rsp_ready, r3_busy;
  logic [31:0] r3_req_src1, r3_req_src2, r3_mul_src1, r3_mul_src2, r3_mul_result, r3_rsp_result;
  logic [4:0]  r3_req_tag, r3_rsp_tag;

  logic [31:0] pipe3 [3];

  int n_cmp = 0;
  int n_err = 0;

  mul_issue_ctrl #(.DATA_W(32), .TAG_W(5), .MUL_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .flush(flush),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .busy(busy)
  );

  mul_issue_ctrl #(.DATA_W(32), .TAG_W(5), .MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(r3_req_valid), .req_ready(r3_req_ready),
    .req_src1(r3_req_src1), .req_src2(r3_req_src2), .req_tag(r3_req_tag),
    .flush(r3_flush),
    .mul_src1(r3_mul_src1), .mul_src2(r3_mul_src2), .mul_result(r3_mul_result),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
    .rsp_result(r3_rsp_result), .rsp_tag(r3_rsp_tag), .busy(r3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiply cell models: one and three register stages.
  always @(posedge clk) begin
    mul_result <= mul_src1 * mul_src2;
    pipe3[0]   <= r3_mul_src1 * r3_mul_src2;
    pipe3[1]   <= pipe3[0];
    pipe3[2]   <= pipe3[1];
  end
  assign r3_mul_result = pipe3[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the latency-1 instance with rsp_ready high and check the full round trip.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] exp);
    int cyc;
    check({name, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_src1 = a; req_src2 = b; req_tag = t; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 12) begin
      step();
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd2);
    check({name, " result"}, 64'(rsp_result), 64'(exp));
    check({name, " tag"}, 64'(rsp_tag), 64'(t));
    step();
    check({name, " idle"}, {62'd0, busy, rsp_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b0; req_src1 = '0; req_src2 = '0; req_tag = '0;
    r3_req_valid = 1'b0; r3_flush = 1'b0; r3_rsp_ready = 1'b0;
    r3_req_src1 = '0; r3_req_src2 = '0; r3_req_tag = '0;

    // Reset state
    step(); step();
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst valid/busy", {62'd0, busy, rsp_valid}, 64'd0);
    check("rst mul_src", {mul_src1, mul_src2}, 64'd0);
    check("rst rsp", {27'd0, rsp_tag, rsp_result}, 64'd0);
    reset = 1'b0;
    #1;
    check("post-rst req_ready", 64'(req_ready), 64'd1);

    // Single op and wrap cases
    do_op("single", 32'd3, 32'd5, 5'd7, 32'd15);
    do_op("wrap_ff", 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 32'hFFFF_FFFE);
    do_op("wrap_1_1", 32'h0001_0001, 32'h0001_0001, 5'd31, 32'h0002_0001);
    do_op("wrap_zero", 32'h0001_0000, 32'h0001_0000, 5'd16, 32'h0000_0000);

    // Backpressure, then back-to-back accept on the rsp_ready pulse
    req_valid = 1'b1; req_src1 = 32'd11; req_src2 = 32'd13; req_tag = 5'd4; rsp_ready = 1'b0;
    step();
    req_src1 = 32'd6; req_src2 = 32'd7; req_tag = 5'd2;
    cyc = 0;
    while (!rsp_valid && cyc < 12) begin step(); cyc++; end
    check("bp latency", 64'(cyc), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp result", 64'(rsp_result), 64'd143);
      check("bp tag", 64'(rsp_tag), 64'd4);
      check("bp valid/busy", {62'd0, busy, rsp_valid}, 64'd3);
      check("bp req_ready", 64'(req_ready), 64'd0);
      step();
    end
    check("bp mul_src held", {mul_src1, mul_src2}, {32'd11, 32'd13});
    rsp_ready = 1'b1;
    #1;
    check("b2b req_ready", 64'(req_ready), 64'd1);
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("b2b wait", {62'd0, busy, rsp_valid}, 64'd2);
    check("b2b mul_src", {mul_src1, mul_src2}, {32'd6, 32'd7});
    cyc = 0;
    while (!rsp_valid && cyc < 12) begin step(); cyc++; end
    check("b2b latency", 64'(cyc), 64'd2);
    check("b2b result", 64'(rsp_result), 64'd42);
    check("b2b tag", 64'(rsp_tag), 64'd2);
    rsp_ready = 1'b1;
    step();
    check("b2b idle", {62'd0, busy, rsp_valid}, 64'd0);

    // Flush in WAIT: no response ever appears
    req_valid = 1'b1; req_src1 = 32'd2; req_src2 = 32'd2; req_tag = 5'd1;
    step();
    req_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush req_ready", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0;
    check("flush wait idle", {62'd0, busy, rsp_valid}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush no rsp", 64'(rsp_valid), 64'd0);
    end
    check("flush keeps mul_src", {mul_src1, mul_src2}, {32'd2, 32'd2});

    // Flush in HOLD
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_src1 = 32'd4; req_src2 = 32'd5; req_tag = 5'd3;
    step();
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 12) begin step(); cyc++; end
    check("hold result", 64'(rsp_result), 64'd20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush hold", {62'd0, busy, rsp_valid}, 64'd0);

    // Flush with a request in IDLE: not accepted
    flush = 1'b1; req_valid = 1'b1; req_src1 = 32'd8; req_src2 = 32'd8; req_tag = 5'd6;
    #1;
    check("flush idle req_ready", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    check("flush idle no accept", 64'(busy), 64'd0);
    check("flush idle mul_src", {mul_src1, mul_src2}, {32'd4, 32'd5});

    // Latency-3 instance; a new request held in WAIT must not disturb the operands
    r3_rsp_ready = 1'b1;
    r3_req_valid = 1'b1; r3_req_src1 = 32'd100; r3_req_src2 = 32'd200; r3_req_tag = 5'd9;
    step();
    r3_req_src1 = 32'd55; r3_req_src2 = 32'd66; r3_req_tag = 5'd10;
    cyc = 0;
    while (!r3_rsp_valid && cyc < 12) begin
      check("lat3 mul_src stable", {r3_mul_src1, r3_mul_src2}, {32'd100, 32'd200});
      check("lat3 req_ready", 64'(r3_req_ready), 64'd0);
      step();
      cyc++;
    end
    r3_req_valid = 1'b0;
    check("lat3 latency", 64'(cyc), 64'd4);
    check("lat3 result", 64'(r3_rsp_result), 64'd20000);
    check("lat3 tag", 64'(r3_rsp_tag), 64'd9);
    step();
    check("lat3 idle", {62'd0, r3_busy, r3_rsp_valid}, 64'd0);

    // Asynchronous reset between edges, mid-WAIT
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_src1 = 32'd12; req_src2 = 32'd12; req_tag = 5'd5;
    step();
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async rst valid/busy", {62'd0, busy, rsp_valid}, 64'd0);
    check("async rst mul_src", {mul_src1, mul_src2}, 64'd0);
    check("async rst rsp", {27'd0, rsp_tag, rsp_result}, 64'd0);
    check("async rst req_ready", 64'(req_ready), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("rel req_ready", 64'(req_ready), 64'd1);
    check("rel no rsp", 64'(rsp_valid), 64'd0);
    do_op("after_rst", 32'd9, 32'd9, 5'd12, 32'd81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
